// File: rtl/prf_free_manager.sv
// prf_free_manager: PRF free list, retirement RAT, and flush-time free-list rebuild by scanning all tags.
module prf_free_manager #(
  parameter int NUM_PRF  = 32,
  parameter int NUM_ARCH = 8,
  parameter int TAG_W    = 5,
  parameter int ARCH_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              retire_valid,
  input  logic [ARCH_W-1:0] retire_Rw,
  input  logic [TAG_W-1:0]  retire_tag_PRF,
  input  logic [TAG_W-1:0]  retire_tag_old,
  input  logic              flush,
  input  logic [ARCH_W-1:0] arf_rd_addr,
  output logic [TAG_W-1:0]  arf_rd_tag,
  output logic [TAG_W:0]    free_count,
  output logic              busy,
  output logic              overflow
);
  typedef enum logic {NORMAL, RECOVER} state_t;
  state_t state, state_d;
  logic [TAG_W-1:0] fifo [NUM_PRF];
  logic [TAG_W-1:0] commit_map [NUM_ARCH];
  logic [TAG_W-1:0] head, tail, wr_data;
  logic [TAG_W:0]   count, k;
  logic normal, flush_go, pop, commit, full, hit, wr_en;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_ARCH; i++) hit = hit | (commit_map[i] == k[TAG_W-1:0]);
  end
  always_comb begin
    normal      = state == NORMAL;
    busy        = !normal;
    full        = count == (TAG_W+1)'(NUM_PRF);
    alloc_valid = normal && count != '0;
    alloc_tag   = fifo[head];
    arf_rd_tag  = commit_map[arf_rd_addr];
    free_count  = count;
    flush_go    = normal && flush;
    pop         = alloc_req && alloc_valid;
    commit      = normal && retire_valid && retire_Rw != '0;
    wr_en       = busy ? !hit : commit && !full;
    wr_data     = busy ? k[TAG_W-1:0] : retire_tag_old;
    state_d     = flush_go ? RECOVER : (busy && k == (TAG_W+1)'(NUM_PRF-1)) ? NORMAL : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= NORMAL;
    else state <= state_d;
  // Flush discards the same-cycle pop/push; the map update still lands so the scan sees it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUM_ARCH; i++) commit_map[i] <= TAG_W'(i);
      for (int j = 0; j < NUM_PRF; j++) fifo[j] <= (j < NUM_PRF-NUM_ARCH) ? TAG_W'(NUM_ARCH+j) : '0;
      head     <= '0;
      tail     <= TAG_W'(NUM_PRF-NUM_ARCH);
      count    <= (TAG_W+1)'(NUM_PRF-NUM_ARCH);
      k        <= '0;
      overflow <= 1'b0;
    end else begin
      if (commit) commit_map[retire_Rw] <= retire_tag_PRF;
      if (flush_go) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        k     <= '0;
      end else begin
        if (wr_en) begin
          fifo[tail] <= wr_data;
          tail       <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        count <= count + (TAG_W+1)'(wr_en) - (TAG_W+1)'(pop);
        if (busy) k <= k + 1'b1;
        if (commit && full) overflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_prf_free_manager.sv
// tb_prf_free_manager: directed stimulus checked every cycle against a queue-based free-list model.
module tb_prf_free_manager;
  logic clk = 0, rst, alloc_req, alloc_valid, retire_valid, flush, busy, overflow;
  logic [4:0] alloc_tag, retire_tag_PRF, retire_tag_old, arf_rd_tag;
  logic [2:0] retire_Rw, arf_rd_addr;
  logic [5:0] free_count;
  int checks = 0, failures = 0;
  int fl[$];
  int mp[8];
  bit rec, ov;
  int scan;
  int want[$];
  prf_free_manager dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
    .retire_valid(retire_valid), .retire_Rw(retire_Rw), .retire_tag_PRF(retire_tag_PRF),
    .retire_tag_old(retire_tag_old), .flush(flush), .arf_rd_addr(arf_rd_addr), .arf_rd_tag(arf_rd_tag),
    .free_count(free_count), .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask
  function automatic bit mapped(int t);
    foreach (mp[i]) if (mp[i] == t) return 1;
    return 0;
  endfunction
  function automatic int partial();
    int n = 0;
    for (int t = 0; t < scan; t++) if (!mapped(t)) n++;
    return n;
  endfunction
  // Model: free list as a queue; recovery yields every unmapped tag in ascending order.
  always @(posedge clk or negedge rst) begin
    bit ret, was_full, do_pop;
    if (!rst) begin
      fl.delete();
      for (int t = 8; t < 32; t++) fl.push_back(t);
      foreach (mp[i]) mp[i] = i;
      rec = 0; scan = 0; ov = 0;
    end else if (rec) begin
      scan++;
      if (scan == 32) begin
        rec = 0;
        fl.delete();
        for (int t = 0; t < 32; t++) if (!mapped(t)) fl.push_back(t);
      end
    end else begin
      ret = retire_valid && retire_Rw != 0;
      was_full = fl.size() == 32;
      do_pop = alloc_req && fl.size() != 0;
      if (ret) mp[retire_Rw] = retire_tag_PRF;
      if (flush) begin
        fl.delete(); rec = 1; scan = 0;
      end else begin
        if (do_pop) void'(fl.pop_front());
        if (ret && was_full) ov = 1;
        else if (ret) fl.push_back(retire_tag_old);
      end
    end
  end
  always @(negedge clk) begin
    chk("valid", alloc_valid, !rec && fl.size() != 0);
    if (!rec && fl.size() != 0) chk("tag", alloc_tag, fl[0]);
    chk("count", free_count, rec ? partial() : fl.size());
    chk("busy", busy, rec);
    chk("overflow", overflow, ov);
    chk("arf", arf_rd_tag, mp[arf_rd_addr]);
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic ret(input int rw, input int p, input int o);
    retire_valid = 1; retire_Rw = 3'(rw); retire_tag_PRF = 5'(p); retire_tag_old = 5'(o);
    tick();
    retire_valid = 0;
  endtask
  initial begin
    rst = 0; alloc_req = 0; retire_valid = 0; retire_Rw = 0; retire_tag_PRF = 0; retire_tag_old = 0;
    flush = 0; arf_rd_addr = 0;
    repeat (2) tick();
    rst = 1;
    @(negedge clk);
    chk("rst_tag", alloc_tag, 8); chk("rst_cnt", free_count, 24); chk("rst_valid", alloc_valid, 1);
    tick();
    alloc_req = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); chk("drain_tag", alloc_tag, 8 + i); chk("drain_cnt", free_count, 24 - i);
      tick();
    end
    alloc_req = 0;
    @(negedge clk); chk("empty_valid", alloc_valid, 0); chk("empty_cnt", free_count, 0);
    tick();
    retire_valid = 1; retire_Rw = 3; retire_tag_PRF = 8; retire_tag_old = 3; arf_rd_addr = 3;
    @(negedge clk); chk("no_bypass", alloc_valid, 0); chk("arf_before", arf_rd_tag, 3);
    tick();
    retire_valid = 0;
    @(negedge clk);
    chk("ret_valid", alloc_valid, 1); chk("ret_tag", alloc_tag, 3);
    chk("ret_cnt", free_count, 1); chk("arf_after", arf_rd_tag, 8);
    tick();
    for (int i = 0; i < 9; i++) ret(6, 6, 10 + i);
    alloc_req = 1;
    ret(5, 5, 5);
    alloc_req = 0;
    @(negedge clk); chk("simul_cnt", free_count, 10);
    tick();
    alloc_req = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (i == 9) chk("tag5_head", alloc_tag, 5);
      tick();
    end
    alloc_req = 0;
    arf_rd_addr = 0;
    ret(0, 20, 21);
    @(negedge clk); chk("rw0_cnt", free_count, 0); chk("rw0_arf", arf_rd_tag, 0);
    tick();
    ret(1, 12, 1);
    retire_valid = 1; retire_Rw = 3; retire_tag_PRF = 9; retire_tag_old = 8; flush = 1; alloc_req = 1;
    tick();
    flush = 0; retire_Rw = 2; retire_tag_PRF = 30; retire_tag_old = 30;
    for (int i = 0; i < 32; i++) begin
      flush = (i == 5);
      @(negedge clk); chk("rec_busy", busy, 1); chk("rec_valid", alloc_valid, 0);
      tick();
    end
    flush = 0; retire_valid = 0; arf_rd_addr = 1;
    want = '{1, 3, 8, 10, 11};
    for (int t = 13; t < 32; t++) want.push_back(t);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("rec_done_busy", busy, 0); chk("rec_cnt", free_count, 24); chk("rec_arf", arf_rd_tag, 12);
      end
      chk("rec_tag", alloc_tag, want[i]);
      tick();
    end
    alloc_req = 0;
    flush = 1;
    tick();
    flush = 0;
    repeat (10) tick();
    rst = 0;
    #1;
    chk("mid_rst_cnt", free_count, 24); chk("mid_rst_busy", busy, 0); chk("mid_rst_tag", alloc_tag, 8);
    for (int a = 0; a < 8; a++) begin
      arf_rd_addr = 3'(a);
      #1 chk("mid_rst_map", arf_rd_tag, a);
    end
    tick();
    rst = 1;
    for (int i = 0; i < 8; i++) ret(1, i, i);
    @(negedge clk); chk("full_cnt", free_count, 32); chk("full_ovf", overflow, 0);
    tick();
    ret(2, 2, 2);
    @(negedge clk); chk("ovf_set", overflow, 1); chk("ovf_cnt", free_count, 32);
    repeat (2) tick();
    chk("ovf_sticky", overflow, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prf_free_manager.md
Name: prf_free_manager

Overview:
- Receiving end of the ROB retire port, and the source of physical register tags for rename.
- Holds a circular free list of PRF tags: one tag is popped per renamed instruction; the retiring instruction's old tag (tag_Rw_old) is pushed back.
- Keeps the committed architectural-to-physical map (retirement RAT).
- On flush, rebuilds the free list from the committed map with a multi-cycle scan.

Parameters:
- NUM_PRF, 32, number of physical registers (power of 2).
- NUM_ARCH, 8, number of architectural registers.
- TAG_W, 5, PRF tag width, log2(NUM_PRF).
- ARCH_W, 3, architectural index width, log2(NUM_ARCH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- alloc_req  in  1  rename consumes alloc_tag this cycle
- alloc_valid  out  1  a free tag is available
- alloc_tag  out  TAG_W  head of the free list
- retire_valid  in  1  ROB retires one instruction (RegWr_out qualified by the ROB)
- retire_Rw  in  ARCH_W  destination architectural register
- retire_tag_PRF  in  TAG_W  new physical tag, now committed
- retire_tag_old  in  TAG_W  previous mapping, to be freed
- flush  in  1  one-cycle pulse (ROB stop); start recovery
- arf_rd_addr  in  ARCH_W  committed-map read index
- arf_rd_tag  out  TAG_W  commit_map[arf_rd_addr], combinational
- free_count  out  TAG_W+1  number of tags in the free list
- busy  out  1  recovery in progress
- overflow  out  1  sticky error: push attempted while list full

Behaviour:
- Storage:
  - fifo[NUM_PRF] of TAG_W bits.
  - head and tail pointers, TAG_W bits each, wrap naturally.
  - count, TAG_W+1 bits.
  - commit_map[NUM_ARCH].
  - 2-state FSM: NORMAL and RECOVER.
  - scan counter k, TAG_W+1 bits.
- Reset (async, rst=0):
  - commit_map[i]=i.
  - fifo[j]=NUM_ARCH+j for j<NUM_PRF-NUM_ARCH.
  - head=0, tail=NUM_PRF-NUM_ARCH, count=NUM_PRF-NUM_ARCH (24).
  - state=NORMAL, k=0, overflow=0, busy=0.
  - Resulting outputs after reset: alloc_valid=1, alloc_tag=8, free_count=24.
  - Reset mid-RECOVER is identical to a cold reset.
- alloc_valid = (state==NORMAL) && (count!=0).
- alloc_tag = fifo[head], combinational.
- Pop:
  - Occurs on alloc_req && alloc_valid: head+1, count-1.
  - alloc_req while alloc_valid=0 is ignored and causes no error.
- Retire in NORMAL, when retire_valid=1:
  - If retire_Rw!=0: commit_map[retire_Rw] <= retire_tag_PRF; fifo[tail] <= retire_tag_old; tail+1, count+1.
  - If retire_Rw==0: ignored; no map update, no push. The ROB halts on this case.
- Simultaneous pop and push in one cycle: count unchanged; both pointers advance.
- No same-cycle bypass. With count==0 and a retire, alloc_valid stays 0 that cycle; the tag becomes available next cycle.
- Push with count==NUM_PRF: push dropped, overflow<=1 (sticky until reset).
- flush in NORMAL:
  - A retire in the same cycle is applied to commit_map first.
  - Then state<=RECOVER, head<=0, tail<=0, count<=0, k<=0.
  - Any same-cycle pop or push to the free list is discarded.
- RECOVER, one tag per cycle:
  - If k matches no commit_map entry (parallel compare against all NUM_ARCH entries): fifo[tail]<=k, tail+1, count+1.
  - k<=k+1.
  - When k==NUM_PRF-1 is processed: state<=NORMAL next edge.
- Recovery lasts exactly NUM_PRF cycles with busy=1.
- First cycle with alloc_valid=1 is NUM_PRF cycles after the flush edge.
- Final count = NUM_PRF-NUM_ARCH (the map holds distinct tags). Free tags end up in ascending order.
- During RECOVER: alloc_req, retire_valid and flush are ignored; alloc_valid=0.
- arf_rd_tag reflects commit_map updates from the next cycle onward.
- busy = (state==RECOVER).
- free_count = count.

Test Plan:
- Reset release, then alloc_req held for 24 cycles -> tags 8,9,…,31 in order, free_count 24→0, then alloc_valid=0.
- From the 24-cycle drain state: retire_valid, Rw=3, tag_PRF=8, tag_old=3 -> next cycle alloc_valid=1, alloc_tag=3, free_count=1; arf_rd_addr=3 reads 8.
- Simultaneous alloc_req and retire (Rw=5, tag_old=5) with count=10 -> count stays 10; 5 reaches the head after 10 pops.
- Retire with retire_Rw=0 -> commit_map, count and tail unchanged.
- After commit_map becomes {0,12,2,9,4,5,6,7}, pulse flush:
  - busy=1 for 32 cycles.
  - Then alloc_valid=1, free_count=24.
  - Pops yield 1,3,8,10,11,13..31.
- Assert rst low at scan k=10 -> immediately free_count=24, busy=0, alloc_tag=8, commit_map identity; flush during RECOVER has no effect.
